// File: rtl/adc_packer_pkg.sv
// Shared types, channel-mode encodings and header layout helpers for the ADC frame packer.
package adc_packer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_GUARD = 2'd2
    } state_e;

    localparam logic [1:0] CHM_FIXED     = 2'd0;
    localparam logic [1:0] CHM_RR_SAMPLE = 2'd1;
    localparam logic [1:0] CHM_RR_FRAME  = 2'd2;

    function automatic int ch_width(input int num_ch);
        return (num_ch <= 2) ? 1 : $clog2(num_ch);
    endfunction

    // Header sits directly above the sample slots: WordCnt, channel, Switcher, Overflow.
    function automatic int hdr_wcnt_lsb(input int samples, input int sample_w);
        return samples * sample_w;
    endfunction

    function automatic int hdr_ch_lsb(input int samples, input int sample_w, input int cnt_w);
        return samples * sample_w + cnt_w;
    endfunction

    function automatic int hdr_sw_bit(input int samples, input int sample_w, input int cnt_w,
                                      input int ch_w);
        return samples * sample_w + cnt_w + ch_w;
    endfunction

    function automatic int hdr_ov_bit(input int samples, input int sample_w, input int cnt_w,
                                      input int ch_w);
        return samples * sample_w + cnt_w + ch_w + 1;
    endfunction

    function automatic bit word_w_ok(input int word_w, input int samples, input int sample_w,
                                     input int cnt_w, input int ch_w);
        return word_w >= samples * sample_w + cnt_w + ch_w + 2;
    endfunction

endpackage

// File: rtl/packer_timing.sv
// Frame sequencer: IDLE/RUN/GUARD FSM, slot/word/frame counters, configuration shadows,
// optical start pulse and switcher drive.
module packer_timing
    import adc_packer_pkg::*;
#(
    parameter int SAMPLES = 6,
    parameter int CNT_W   = 13,
    parameter int FCNT_W  = 24,
    localparam int PT_W   = (SAMPLES > 1) ? $clog2(SAMPLES) : 1
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              enable_i,
    input  logic [CNT_W-1:0]  frame_length_i,
    input  logic [CNT_W-1:0]  pulse_offset_i,
    input  logic [7:0]        pulse_width_i,
    input  logic [1:0]        ch_mode_i,
    input  logic [3:0]        guard_ticks_i,
    input  logic [FCNT_W-1:0] frames_to_switch_i,
    output logic              capture_o,
    output logic              wrap_o,
    output logic              frame_start_o,
    output logic              frame_end_o,
    output logic [PT_W-1:0]   point_cnt_o,
    output logic [CNT_W-1:0]  word_cnt_o,
    output logic [1:0]        ch_mode_o,
    output logic              start_pulse_o,
    output logic              switcher_o
);

    localparam int PE_W = CNT_W + 1;

    state_e            state_q;
    logic [PT_W-1:0]   point_q;
    logic [CNT_W-1:0]  word_q;
    logic [FCNT_W-1:0] frame_cnt_q;
    logic [3:0]        guard_cnt_q;
    logic [CNT_W-1:0]  frame_len_q;
    logic [CNT_W-1:0]  pulse_off_q;
    logic [7:0]        pulse_w_q;
    logic [1:0]        ch_mode_q;
    logic [3:0]        guard_q;
    logic [FCNT_W-1:0] fts_q;
    logic              pulse_q;
    logic              switcher_q;

    logic              capture_s;
    logic              wrap_s;
    logic              last_word_s;
    logic              frame_start_s;
    logic              frame_end_s;
    logic [PE_W-1:0]   pulse_end_s;

    // Decode capture/wrap/frame-boundary events from the current state.
    always_comb begin
        capture_s     = (state_q == ST_RUN);
        wrap_s        = capture_s && (point_q == PT_W'(SAMPLES - 1));
        last_word_s   = (word_q == frame_len_q);
        frame_start_s = (state_q == ST_IDLE) && enable_i;
        frame_end_s   = (wrap_s && last_word_s && (guard_q == 4'd0)) ||
                        ((state_q == ST_GUARD) && (guard_cnt_q == guard_q - 4'd1));
        pulse_end_s   = {1'b0, pulse_off_q} + PE_W'(pulse_w_q);
    end

    // Sequencer state, counters, shadows and registered pulse/switcher outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_IDLE;
            point_q     <= '0;
            word_q      <= '0;
            frame_cnt_q <= '0;
            guard_cnt_q <= 4'd0;
            frame_len_q <= '0;
            pulse_off_q <= '0;
            pulse_w_q   <= 8'd0;
            ch_mode_q   <= 2'd0;
            guard_q     <= 4'd0;
            fts_q       <= '0;
            pulse_q     <= 1'b0;
            switcher_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (enable_i) begin
                        state_q <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (wrap_s) begin
                        point_q <= '0;
                        if (pulse_w_q != 8'd0) begin
                            if (word_q == pulse_off_q) begin
                                pulse_q <= 1'b1;
                            end else if ({1'b0, word_q} == pulse_end_s) begin
                                pulse_q <= 1'b0;
                            end
                        end
                        if (!last_word_s) begin
                            word_q <= word_q + CNT_W'(1);
                        end else if (guard_q != 4'd0) begin
                            state_q     <= ST_GUARD;
                            guard_cnt_q <= 4'd0;
                        end
                    end else begin
                        point_q <= point_q + PT_W'(1);
                    end
                end
                ST_GUARD: begin
                    if (!frame_end_s) begin
                        guard_cnt_q <= guard_cnt_q + 4'd1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase

            // Frame end overrides whatever the state branch decided for the pulse and word count.
            if (frame_end_s) begin
                pulse_q <= 1'b0;
                word_q  <= '0;
                if (frame_cnt_q >= fts_q) begin
                    frame_cnt_q <= '0;
                    switcher_q  <= ~switcher_q;
                end else begin
                    frame_cnt_q <= frame_cnt_q + FCNT_W'(1);
                end
                state_q <= enable_i ? ST_RUN : ST_IDLE;
            end

            if (frame_start_s || (frame_end_s && enable_i)) begin
                frame_len_q <= frame_length_i;
                pulse_off_q <= pulse_offset_i;
                pulse_w_q   <= pulse_width_i;
                ch_mode_q   <= ch_mode_i;
                guard_q     <= guard_ticks_i;
                fts_q       <= frames_to_switch_i;
            end
        end
    end

    assign capture_o     = capture_s;
    assign wrap_o        = wrap_s;
    assign frame_start_o = frame_start_s;
    assign frame_end_o   = frame_end_s;
    assign point_cnt_o   = point_q;
    assign word_cnt_o    = word_q;
    assign ch_mode_o     = ch_mode_q;
    assign start_pulse_o = pulse_q;
    assign switcher_o    = switcher_q;

endmodule

// File: rtl/adc_frame_packer.sv
// Packs SAMPLES ADC samples plus a header into one word per SAMPLES clocks, with channel
// selection, drop accounting and the frame timing outputs.
module adc_frame_packer
    import adc_packer_pkg::*;
#(
    parameter int NUM_CH   = 2,
    parameter int SAMPLE_W = 8,
    parameter int SAMPLES  = 6,
    parameter int CNT_W    = 13,
    parameter int WORD_W   = 64,
    parameter int FCNT_W   = 24,
    localparam int CH_W    = ch_width(NUM_CH)
) (
    input  logic                       InputClock,
    input  logic                       ResetN,
    input  logic [NUM_CH*SAMPLE_W-1:0] AdcData,
    input  logic                       Enable,
    input  logic [CNT_W-1:0]           FrameLength,
    input  logic [CNT_W-1:0]           PulseOffset,
    input  logic [7:0]                 PulseWidth,
    input  logic [1:0]                 ChMode,
    input  logic [CH_W-1:0]            ChSelect,
    input  logic [3:0]                 GuardTicks,
    input  logic [FCNT_W-1:0]          FramesToSwitch,
    input  logic                       ClearStatus,
    output logic [WORD_W-1:0]          OutData,
    output logic                       OutValid,
    input  logic                       OutReady,
    output logic                       StartPulse,
    output logic                       Switcher,
    output logic                       Overflow,
    output logic [15:0]                DropCount
);

    localparam int PT_W   = (SAMPLES > 1) ? $clog2(SAMPLES) : 1;
    localparam int DATA_W = SAMPLES * SAMPLE_W;
    localparam int WC_LSB = hdr_wcnt_lsb(SAMPLES, SAMPLE_W);
    localparam int CH_LSB = hdr_ch_lsb(SAMPLES, SAMPLE_W, CNT_W);
    localparam int SW_BIT = hdr_sw_bit(SAMPLES, SAMPLE_W, CNT_W, CH_W);
    localparam int OV_BIT = hdr_ov_bit(SAMPLES, SAMPLE_W, CNT_W, CH_W);

    if (!word_w_ok(WORD_W, SAMPLES, SAMPLE_W, CNT_W, CH_W)) begin : g_word_w_check
        $error("adc_frame_packer: WORD_W too narrow for samples plus header");
    end

    logic                capture_s;
    logic                wrap_s;
    logic                frame_start_s;
    logic                frame_end_s;
    logic [PT_W-1:0]     point_s;
    logic [CNT_W-1:0]    word_cnt_s;
    logic [1:0]          ch_mode_s;
    logic                start_pulse_s;
    logic                switcher_s;

    logic [CH_W-1:0]     ch_rr_q;
    logic [CH_W-1:0]     ch_fr_q;
    logic [CH_W-1:0]     ch0_q;
    logic [CH_W-1:0]     active_ch_s;
    logic [SAMPLE_W-1:0] sample_s;
    logic [DATA_W-1:0]   slots_q;
    logic [DATA_W-1:0]   slots_d;
    logic [WORD_W-1:0]   word_s;
    logic [WORD_W-1:0]   out_data_q;
    logic                out_valid_q;
    logic                overflow_q;
    logic [15:0]         drop_cnt_q;
    logic                drop_s;

    packer_timing #(
        .SAMPLES (SAMPLES),
        .CNT_W   (CNT_W),
        .FCNT_W  (FCNT_W)
    ) u_timing (
        .clk_i              (InputClock),
        .rst_ni             (ResetN),
        .enable_i           (Enable),
        .frame_length_i     (FrameLength),
        .pulse_offset_i     (PulseOffset),
        .pulse_width_i      (PulseWidth),
        .ch_mode_i          (ChMode),
        .guard_ticks_i      (GuardTicks),
        .frames_to_switch_i (FramesToSwitch),
        .capture_o          (capture_s),
        .wrap_o             (wrap_s),
        .frame_start_o      (frame_start_s),
        .frame_end_o        (frame_end_s),
        .point_cnt_o        (point_s),
        .word_cnt_o         (word_cnt_s),
        .ch_mode_o          (ch_mode_s),
        .start_pulse_o      (start_pulse_s),
        .switcher_o         (switcher_s)
    );

    // Channel for the current capture; fixed mode follows ChSelect live.
    always_comb begin
        case (ch_mode_s)
            CHM_RR_SAMPLE: active_ch_s = ch_rr_q;
            CHM_RR_FRAME:  active_ch_s = ch_fr_q;
            default:       active_ch_s = ChSelect;
        endcase
        sample_s = AdcData[active_ch_s * SAMPLE_W +: SAMPLE_W];
    end

    // Round-robin pointers: per-sample restarts each word, per-frame steps at each frame end.
    always_ff @(posedge InputClock or negedge ResetN) begin
        if (!ResetN) begin
            ch_rr_q <= '0;
            ch_fr_q <= '0;
            ch0_q   <= '0;
        end else begin
            if (wrap_s) begin
                ch_rr_q <= '0;
            end else if (capture_s) begin
                ch_rr_q <= (ch_rr_q == CH_W'(NUM_CH - 1)) ? '0 : ch_rr_q + CH_W'(1);
            end
            if (frame_start_s) begin
                ch_fr_q <= ChSelect;
            end else if (frame_end_s) begin
                ch_fr_q <= (ch_fr_q == CH_W'(NUM_CH - 1)) ? '0 : ch_fr_q + CH_W'(1);
            end
            if (capture_s && (point_s == '0)) begin
                ch0_q <= active_ch_s;
            end
        end
    end

    // Slot image including the sample being captured this cycle, plus the header above it.
    always_comb begin
        slots_d = slots_q;
        if (capture_s) begin
            slots_d[point_s * SAMPLE_W +: SAMPLE_W] = sample_s;
        end else begin
            slots_d = slots_q;
        end
        word_s                    = '0;
        word_s[DATA_W-1:0]        = slots_d;
        word_s[WC_LSB +: CNT_W]   = word_cnt_s;
        word_s[CH_LSB +: CH_W]    = (point_s == '0) ? active_ch_s : ch0_q;
        word_s[SW_BIT]            = switcher_s;
        word_s[OV_BIT]            = overflow_q;
    end

    assign drop_s = out_valid_q && !OutReady;

    // Slot storage, output word register and drop status.
    always_ff @(posedge InputClock or negedge ResetN) begin
        if (!ResetN) begin
            slots_q     <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            overflow_q  <= 1'b0;
            drop_cnt_q  <= 16'd0;
        end else begin
            if (capture_s) begin
                slots_q <= slots_d;
            end
            out_valid_q <= wrap_s;
            if (wrap_s) begin
                out_data_q <= word_s;
            end
            if (drop_s) begin
                overflow_q <= 1'b1;
                if (ClearStatus) begin
                    drop_cnt_q <= 16'd1;
                end else if (drop_cnt_q != 16'hFFFF) begin
                    drop_cnt_q <= drop_cnt_q + 16'd1;
                end
            end else if (ClearStatus) begin
                overflow_q <= 1'b0;
                drop_cnt_q <= 16'd0;
            end
        end
    end

    assign OutData    = out_data_q;
    assign OutValid   = out_valid_q;
    assign StartPulse = start_pulse_s;
    assign Switcher   = switcher_s;
    assign Overflow   = overflow_q;
    assign DropCount  = drop_cnt_q;

endmodule
